// File: rtl/delay_pipe_drain_pkg.sv
// rtl/delay_pipe_drain_pkg.sv - shared types, defaults and pointer helper for delay_pipe_drain
//
// Purpose: default configuration of the drain block (pipe latency, width,
// FIFO depth), pointer/count types sized for that default configuration,
// and a pointer increment that wraps explicitly so any depth works.
// Ports: none (package).
package delay_pipe_drain_pkg;

  localparam int unsigned N_DEF     = 5;
  localparam int unsigned W_DEF     = 32;
  // N+2 entries let a credit return in time to keep the loop at full rate.
  localparam int unsigned DEPTH_DEF = N_DEF + 2;

  typedef logic [$clog2(DEPTH_DEF)-1:0]   ptr_t;
  typedef logic [$clog2(DEPTH_DEF+1)-1:0] cnt_t;

  // Wraps at depth-1 rather than at a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/delay_pipe_drain_fifo.sv
// rtl/delay_pipe_drain_fifo.sv - DEPTH-entry FIFO capturing the delay-pipe output
//
// Purpose: storage, read/write pointers and occupancy count. The head entry
// is read combinationally; a pushed word becomes visible one cycle later.
// A push while full is only accepted when a pop frees the head slot in the
// same cycle; otherwise it is ignored (the caller flags the overflow).
// Ports:
//   clk, rst   clock, synchronous active-low reset (pointers/count only)
//   push_i     write wdata_i at the tail
//   pop_i      remove the head entry
//   wdata_i    data to write
//   rdata_o    head entry data
//   empty_o    count == 0
//   full_o     count == DEPTH
module delay_pipe_drain_fifo
  import delay_pipe_drain_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign rd_en   = pop_i & ~empty_o;
  // When full, the slot under wr_ptr is the head being popped this cycle,
  // so writing it is safe: the head was already read combinationally.
  assign wr_en   = push_i & (~full_o | rd_en);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (rd_en) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately not reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/delay_pipe_drain.sv
// rtl/delay_pipe_drain.sv - credit-gated drain FIFO at the output of a fixed-latency delay pipe
//
// Purpose: captures every word leaving a non-stallable delay pipe into a
// FIFO and presents it on a valid/ready interface. A credit counter, one
// credit per FIFO entry, gates the issuer so each word in flight has a slot.
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   issue_vld   issuer wants to launch a word into the delay pipe
//   issue_rdy   a credit is available
//   in, in_vld  delay-pipe output (no backpressure)
//   out,out_vld FIFO head / non-empty
//   out_rdy     consumer accepts the head
//   credits_r   current credit count
//   ovf_r       sticky: push arrived while full with no pop
//   err_r       sticky: issue_vld seen without a credit
module delay_pipe_drain
  import delay_pipe_drain_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = N + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_vld,
  output logic                       issue_rdy,
  input  logic [W-1:0]               in,
  input  logic                       in_vld,
  output logic [W-1:0]               out,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] credits_r,
  output logic                       ovf_r,
  output logic                       err_r
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] credits_q, credits_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          issue;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  assign issue_rdy = (credits_q != '0);
  assign issue     = issue_vld & issue_rdy;
  assign pop       = out_vld & out_rdy;
  assign out_vld   = ~fifo_empty;

  always_comb begin
    // A popped slot becomes a credit one cycle later, through the register.
    credits_d = credits_q - CW'(issue) + CW'(pop);
    ovf_d     = ovf_q | (in_vld & fifo_full & ~pop);
    err_d     = err_q | (issue_vld & ~issue_rdy);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credits_q <= CW'(DEPTH);
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign credits_r = credits_q;
  assign ovf_r     = ovf_q;
  assign err_r     = err_q;

  delay_pipe_drain_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_vld),
    .pop_i   (pop),
    .wdata_i (in),
    .rdata_o (out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule
